mux4_rr_arbiter: RTL and testbench

Shares one DATA_W-bit 4:1 mux output channel between four requesters A–D.
- Round-robin FSM picks the owner and drives the mux select (S1,S0 as sel[1:0]).
- Registers the selected data with a valid flag.
- Bounds each owner's tenure to MAX_HOLD cycles so no requester starves.
- Sits between the requester blocks and the shared downstream consumer.

---
 rtl/mux4_arb_pkg.sv | 16 +
 rtl/rr_pick4.sv | 33 +++
 rtl/mux4_rr_arbiter.sv | 127 ++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mux4_arb_pkg.sv
// Shared types and helpers for the four-way round-robin mux arbiter.
package mux4_arb_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first unmasked request after last, wrapping mod 4.
// Zero latency; no flow control.
module rr_pick4
    import mux4_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [1:0]         last,
    output logic [1:0]         pick,
    output logic               any
);

    logic [NUM_REQ-1:0] eff_req;
    logic [1:0]         idx;

    assign eff_req = req & ~mask;

    // Walk from the farthest candidate (last itself) to the nearest (last+1)
    // so the nearest set request overwrites the others.
    always_comb begin
        pick = last;
        any  = 1'b0;
        idx  = last;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = last + 2'(k);
            if (eff_req[idx]) begin
                pick = idx;
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of a shared 4:1 data mux with bounded tenure (MAX_HOLD cycles).
// gnt/sel one edge after request, dout/dout_valid one edge later; no backpressure from consumer.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int DATA_W   = 2,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        req,
    input  logic [DATA_W-1:0] din_a,
    input  logic [DATA_W-1:0] din_b,
    input  logic [DATA_W-1:0] din_c,
    input  logic [DATA_W-1:0] din_d,
    output logic [3:0]        gnt,
    output logic [1:0]        sel,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid
);

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_e            state_q, state_d;
    logic [3:0]        gnt_q, gnt_d;
    logic [1:0]        sel_q, sel_d;
    logic [1:0]        last_q, last_d;
    logic [3:0]        hold_q, hold_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dvld_q, dvld_d;

    logic [3:0]        pick_mask;
    logic [1:0]        pick;
    logic              pick_any;
    logic              owner_req;
    logic [DATA_W-1:0] mux_dat;

    // While granted, the picker only matters on release, where the owner is excluded.
    assign pick_mask = (state_q == GRANT) ? onehot(sel_q) : 4'b0000;
    assign owner_req = req[sel_q];

    rr_pick4 u_pick (
        .req  (req),
        .mask (pick_mask),
        .last (last_q),
        .pick (pick),
        .any  (pick_any)
    );

    always_comb begin
        case (sel_q)
            2'd0:    mux_dat = din_a;
            2'd1:    mux_dat = din_b;
            2'd2:    mux_dat = din_c;
            default: mux_dat = din_d;
        endcase
    end

    assign dvld_d = (state_q == GRANT) && owner_req;
    assign dout_d = dvld_d ? mux_dat : dout_q;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    sel_d   = pick;
                    gnt_d   = onehot(pick);
                    last_d  = pick;
                    hold_d  = 4'd0;
                end else begin
                    gnt_d = 4'b0000;
                end
            end
            GRANT: begin
                if (owner_req && (hold_q < HOLD_LAST)) begin
                    hold_d = hold_q + 4'd1;
                end else if (pick_any) begin
                    sel_d  = pick;
                    gnt_d  = onehot(pick);
                    last_d = pick;
                    hold_d = 4'd0;
                end else if (owner_req) begin
                    hold_d = 4'd0;
                end else begin
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;
            hold_q  <= 4'd0;
            dout_q  <= '0;
            dvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            dout_q  <= dout_d;
            dvld_q  <= dvld_d;
        end
    end

    assign gnt        = gnt_q;
    assign sel        = sel_q;
    assign dout       = dout_q;
    assign dout_valid = dvld_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Randomised + directed bench for mux4_rr_arbiter with a tenure-level reference model and scoreboard.
module tb_mux4_rr_arbiter;

    localparam int DATA_W   = 2;
    localparam int MAX_HOLD = 4;

    typedef struct packed {
        logic [3:0]        gnt;
        logic [1:0]        sel;
        logic [DATA_W-1:0] dout;
        logic              dvld;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic [3:0]        req;
    logic [DATA_W-1:0] din_a, din_b, din_c, din_d;
    logic [3:0]        gnt;
    logic [1:0]        sel;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;

    mux4_rr_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .din_a      (din_a),
        .din_b      (din_b),
        .din_c      (din_c),
        .din_d      (din_d),
        .gnt        (gnt),
        .sel        (sel),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: owner (-1 = nobody), cycles granted so far in this tenure, last winner.
    int                m_owner = -1;
    int                m_used  = 0;
    int                m_last  = 3;
    int                m_sel   = 0;
    logic [DATA_W-1:0] m_dout  = '0;
    logic              m_dvld  = 1'b0;

    function automatic int search(input logic [3:0] r, input int from, input int excl);
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (from + k) % 4;
            if (i != excl && r[i]) return i;
        end
        return -1;
    endfunction

    function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endfunction

    task automatic step(input logic rst, input logic [3:0] r,
                        input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                        input logic [DATA_W-1:0] c, input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] dv[4];
        exp_t e;
        int   w;
        rst_n = rst; req = r;
        din_a = a; din_b = b; din_c = c; din_d = d;
        dv[0] = a; dv[1] = b; dv[2] = c; dv[3] = d;
        if (!rst) begin
            m_owner = -1; m_used = 0; m_last = 3; m_sel = 0;
            m_dout  = '0; m_dvld = 1'b0;
        end else begin
            m_dvld = (m_owner >= 0) && r[m_owner];
            if (m_dvld) m_dout = dv[m_owner];
            if (m_owner < 0) begin
                w = search(r, m_last, -1);
                if (w >= 0) begin
                    m_owner = w; m_last = w; m_sel = w; m_used = 1;
                end
            end else if (r[m_owner] && m_used < MAX_HOLD) begin
                m_used++;
            end else begin
                w = search(r, m_last, m_owner);
                if (w >= 0) begin
                    m_owner = w; m_last = w; m_sel = w; m_used = 1;
                end else if (r[m_owner]) begin
                    m_used = 1;
                end else begin
                    m_owner = -1;
                end
            end
        end
        e.gnt  = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        e.sel  = 2'(m_sel);
        e.dout = m_dout;
        e.dvld = m_dvld;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: one expectation per edge, sampled 1 time unit after the edge.
    initial begin
        exp_t e;
        logic inv_ok;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("gnt", 8'(gnt), 8'(e.gnt));
                chk("sel", 8'(sel), 8'(e.sel));
                chk("dout_valid", 8'(dout_valid), 8'(e.dvld));
                chk("dout", 8'(dout), 8'(e.dout));
                inv_ok = $onehot0(gnt) && (gnt == 4'b0000 || gnt == (4'b0001 << sel));
                chk("gnt_onehot_sel", 8'(inv_ok), 8'd1);
            end
        end
    end

    initial begin
        logic [3:0] cur_req;
        int         wait_cyc;
        rst_n = 1'b0; req = '0; din_a = '0; din_b = '0; din_c = '0; din_d = '0;

        // Reset with all requesting, then fair rotation A,B,C,D each MAX_HOLD cycles.
        repeat (2) step(1'b0, 4'b1111, 2'd0, 2'd1, 2'd2, 2'd3);
        repeat (18) step(1'b1, 4'b1111, 2'd0, 2'd1, 2'd2, 2'd3);

        // Single requester C: continuous re-grant with no idle gap.
        repeat (2) step(1'b1, 4'b0000, 2'd0, 2'd1, 2'd2, 2'd3);
        repeat (10) step(1'b1, 4'b0100, 2'd1, 2'd3, 2'd2, 2'd0);

        // Early release: B owns for 2 cycles with C pending, then drops.
        repeat (2) step(1'b1, 4'b0000, 2'd0, 2'd1, 2'd2, 2'd3);
        repeat (2) step(1'b1, 4'b0110, 2'd0, 2'd1, 2'd2, 2'd3);
        repeat (3) step(1'b1, 4'b0100, 2'd0, 2'd1, 2'd2, 2'd3);

        // Owner drops while a new source rises in the same cycle.
        repeat (2) step(1'b1, 4'b0001, 2'd3, 2'd1, 2'd2, 2'd0);
        repeat (2) step(1'b1, 4'b1000, 2'd3, 2'd1, 2'd2, 2'd0);

        // last=A then simultaneous B and D: B first, then D; then all drop.
        step(1'b0, 4'b0000, 2'd0, 2'd1, 2'd2, 2'd3);
        repeat (2) step(1'b1, 4'b0001, 2'd0, 2'd1, 2'd2, 2'd3);
        repeat (10) step(1'b1, 4'b1010, 2'd0, 2'd1, 2'd2, 2'd3);
        repeat (3) step(1'b1, 4'b0000, 2'd0, 2'd1, 2'd2, 2'd3);

        // Mid-tenure reset during D's ownership; next grant restarts from A.
        repeat (3) step(1'b1, 4'b1000, 2'd0, 2'd1, 2'd2, 2'd3);
        step(1'b0, 4'b1111, 2'd0, 2'd1, 2'd2, 2'd3);
        repeat (6) step(1'b1, 4'b1111, 2'd0, 2'd1, 2'd2, 2'd3);

        // Random traffic with sticky requests and occasional resets.
        cur_req = 4'b0000;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(3) == 0) cur_req = 4'($urandom_range(15));
            step(($urandom_range(99) != 0), cur_req,
                 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
        end
        step(1'b1, 4'b0000, 2'd0, 2'd0, 2'd0, 2'd0);

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
